smi_frame_arbiter_xn: RTL and testbench



---
 rtl/smi_frame_arbiter_xn_pkg.sv | 31 +++
 rtl/smi_frame_arbiter_xn_skid.sv | 83 ++++++++
 rtl/smi_frame_arbiter_xn.sv | 187 ++++++++++++++++++
 tb/tb_smi_frame_arbiter_xn.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/smi_frame_arbiter_xn_pkg.sv
// ---------------------------------------------------------------------------
// smi_frame_arbiter_xn_pkg
//   Shared SMI definitions for the frame arbiter and its skid stage:
//   eofc field width, arbiter FSM encoding, the Ready/Stop transfer rule and
//   a constant-foldable clog2 used to size port-index fields.
// ---------------------------------------------------------------------------
package smi_frame_arbiter_xn_pkg;

    localparam int EofcWidth = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Number of bits needed to index v entries (0 for v <= 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r++;
        end
        return r;
    endfunction

    // A flit moves across an SMI link when Ready is high and Stop is low.
    function automatic logic smi_xfer(input logic ready, input logic stop);
        return ready & ~stop;
    endfunction

endpackage

// File: rtl/smi_frame_arbiter_xn_skid.sv
// ---------------------------------------------------------------------------
// smi_skid_buffer
//   Two-entry registered SMI pipeline stage (output register + skid
//   register). Upstream Stop is taken purely from the skid occupancy flag,
//   so there is no combinational path from out_stop_i to in_stop_o.
//
//   clk, rstn     clock, asynchronous active-low reset
//   in_ready_i    upstream flit valid
//   in_data_i     upstream payload (Width bits)
//   in_stop_o     upstream backpressure (skid register occupied)
//   out_ready_o   downstream flit valid (registered)
//   out_data_o    downstream payload (registered)
//   out_stop_i    downstream backpressure
// ---------------------------------------------------------------------------
module smi_skid_buffer
    import smi_frame_arbiter_xn_pkg::*;
#(
    parameter int Width = 40
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_ready_i,
    input  logic [Width-1:0] in_data_i,
    output logic             in_stop_o,
    output logic             out_ready_o,
    output logic [Width-1:0] out_data_o,
    input  logic             out_stop_i
);

    logic             out_vld_q,  out_vld_d;
    logic [Width-1:0] out_data_q, out_data_d;
    logic             skid_vld_q, skid_vld_d;
    logic [Width-1:0] skid_data_q, skid_data_d;
    logic             in_acc;
    logic             out_free;

    assign in_acc   = smi_xfer(in_ready_i, skid_vld_q);
    // Output register can take a new entry this cycle if empty or draining.
    assign out_free = ~out_vld_q | ~out_stop_i;

    always_comb begin
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        if (out_free) begin
            if (skid_vld_q) begin
                // Skid holds the older flit; it moves first. in_acc is 0
                // here because the skid was occupied.
                out_vld_d  = 1'b1;
                out_data_d = skid_data_q;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d = in_acc;
                if (in_acc) begin
                    out_data_d = in_data_i;
                end
            end
        end else if (in_acc) begin
            skid_vld_d  = 1'b1;
            skid_data_d = in_data_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
        end else begin
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign in_stop_o   = skid_vld_q;
    assign out_ready_o = out_vld_q;
    assign out_data_o  = out_data_q;

endmodule

// File: rtl/smi_frame_arbiter_xn.sv
// ---------------------------------------------------------------------------
// smi_frame_arbiter_xn
//   Merges NumPorts upstream SMI request streams onto one downstream port.
//   A port is locked from its first flit to its last (eofc != 0), so frames
//   never interleave. Arbitration is round-robin (ArbMode=0) or fixed
//   priority, lowest index wins (ArbMode=1). With StampTag=1 the granted
//   index is written into [TagPortLsb +: PortIdxWidth] of each first flit.
//   The output is fully registered through a 2-entry skid stage.
//
//   clk, rstn        clock, asynchronous active-low reset
//   smiReqInReady    per-port flit valid
//   smiReqInEofc     per-port eofc, port i at [8i+7:8i]
//   smiReqInData     per-port data, port i at [DataWidth*i +: DataWidth]
//   smiReqInStop     per-port backpressure
//   smiReqOutReady   downstream flit valid
//   smiReqOutEofc    downstream eofc
//   smiReqOutData    downstream data
//   smiReqOutStop    downstream backpressure
//   grantValid       a frame is currently locked
//   grantIdx         locked port index, 0 when idle
// ---------------------------------------------------------------------------
module smi_frame_arbiter_xn
    import smi_frame_arbiter_xn_pkg::*;
#(
    parameter  int FlitWidth    = 4,
    parameter  int NumPorts     = 4,
    parameter  int ArbMode      = 0,
    parameter  int StampTag     = 1,
    parameter  int TagPortLsb   = 26,
    localparam int DataWidth    = FlitWidth * 8,
    localparam int PortIdxWidth = (clog2(NumPorts) < 1) ? 1 : clog2(NumPorts)
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [NumPorts-1:0]             smiReqInReady,
    input  logic [NumPorts*EofcWidth-1:0]   smiReqInEofc,
    input  logic [NumPorts*DataWidth-1:0]   smiReqInData,
    output logic [NumPorts-1:0]             smiReqInStop,
    output logic                            smiReqOutReady,
    output logic [EofcWidth-1:0]            smiReqOutEofc,
    output logic [DataWidth-1:0]            smiReqOutData,
    input  logic                            smiReqOutStop,
    output logic                            grantValid,
    output logic [PortIdxWidth-1:0]         grantIdx
);

    localparam int SkidWidth = EofcWidth + DataWidth;

    arb_state_e              state_q, state_d;
    logic [PortIdxWidth-1:0] grant_idx_q, grant_idx_d;
    logic [PortIdxWidth-1:0] rr_ptr_q, rr_ptr_d;
    logic                    first_q, first_d;

    logic                    win_found;
    logic [PortIdxWidth-1:0] win_idx;

    logic                    g_ready;
    logic [EofcWidth-1:0]    g_eofc;
    logic [DataWidth-1:0]    g_data;
    logic [DataWidth-1:0]    st_data;

    logic                    skid_in_ready;
    logic                    skid_full;
    logic                    acc;
    logic                    last_acc;
    logic [SkidWidth-1:0]    skid_out;

    // ------------------------------------------------------------------
    // Winner selection. Scanning from base upward modulo NumPorts is the
    // rotate / priority-encode / rotate-back structure folded into one
    // loop. Round-robin starts just past the last granted port; fixed
    // priority always starts at 0.
    // ------------------------------------------------------------------
    always_comb begin
        int base;
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        base      = (ArbMode == 1) ? 0 : (int'(rr_ptr_q) + 1) % NumPorts;
        idx       = 0;
        for (int k = 0; k < NumPorts; k++) begin
            idx = (base + k) % NumPorts;
            if (!win_found && smiReqInReady[idx]) begin
                win_found = 1'b1;
                win_idx   = PortIdxWidth'(idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Granted-port flit mux and first-flit tag stamping.
    // ------------------------------------------------------------------
    always_comb begin
        g_ready = smiReqInReady[grant_idx_q];
        g_eofc  = smiReqInEofc[EofcWidth*int'(grant_idx_q) +: EofcWidth];
        g_data  = smiReqInData[DataWidth*int'(grant_idx_q) +: DataWidth];
        st_data = g_data;
        if (StampTag != 0 && first_q) begin
            st_data[TagPortLsb +: PortIdxWidth] = grant_idx_q;
        end
    end

    assign skid_in_ready = (state_q == ST_LOCKED) & g_ready;
    assign acc           = smi_xfer(skid_in_ready, skid_full);
    assign last_acc      = acc & (g_eofc != '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= PortIdxWidth'(NumPorts - 1);
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            first_q     <= first_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. The IDLE cycle is the arbitration bubble; no flit
    // is accepted in it because every Stop is high.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        first_d     = first_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d     = ST_LOCKED;
                    grant_idx_d = win_idx;
                    rr_ptr_d    = win_idx;
                    first_d     = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (acc) begin
                    first_d = 1'b0;
                end
                if (last_acc) begin
                    state_d     = ST_IDLE;
                    grant_idx_d = '0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                grant_idx_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Only the locked port sees the skid-full flag; all
    // others are held off.
    // ------------------------------------------------------------------
    always_comb begin
        smiReqInStop = '1;
        if (state_q == ST_LOCKED) begin
            smiReqInStop[grant_idx_q] = skid_full;
        end
        grantValid = (state_q == ST_LOCKED);
        grantIdx   = grant_idx_q;
    end

    smi_skid_buffer #(
        .Width (SkidWidth)
    ) u_skid (
        .clk         (clk),
        .rstn        (rstn),
        .in_ready_i  (skid_in_ready),
        .in_data_i   ({g_eofc, st_data}),
        .in_stop_o   (skid_full),
        .out_ready_o (smiReqOutReady),
        .out_data_o  (skid_out),
        .out_stop_i  (smiReqOutStop)
    );

    assign smiReqOutEofc = skid_out[SkidWidth-1 -: EofcWidth];
    assign smiReqOutData = skid_out[DataWidth-1:0];

endmodule

// File: tb/tb_smi_frame_arbiter_xn.sv
module tb_smi_frame_arbiter_xn;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int TL = 26;

    typedef struct packed {
        logic [7:0]    eofc;
        logic [DW-1:0] data;
    } flit_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NP-1:0]     in_rdy = '0;
    logic [NP*8-1:0]   in_eofc = '0;
    logic [NP*DW-1:0]  in_data = '0;
    logic              out_stop = 1'b0;
    logic              sel = 1'b0;

    logic [NP-1:0] stop_rr, stop_fp, stop_s;
    logic          ordy_rr, ordy_fp, ordy_s;
    logic [7:0]    oeofc_rr, oeofc_fp, oeofc_s;
    logic [DW-1:0] odata_rr, odata_fp, odata_s;
    logic          gv_rr, gv_fp, gv_s;
    logic [1:0]    gi_rr, gi_fp, gi_s;

    always #5 clk = ~clk;

    smi_frame_arbiter_xn #(.FlitWidth(4), .NumPorts(NP), .ArbMode(0), .StampTag(1), .TagPortLsb(TL)) dut_rr (
        .clk(clk), .rstn(rstn), .smiReqInReady(in_rdy), .smiReqInEofc(in_eofc), .smiReqInData(in_data),
        .smiReqInStop(stop_rr), .smiReqOutReady(ordy_rr), .smiReqOutEofc(oeofc_rr), .smiReqOutData(odata_rr),
        .smiReqOutStop(out_stop), .grantValid(gv_rr), .grantIdx(gi_rr));

    smi_frame_arbiter_xn #(.FlitWidth(4), .NumPorts(NP), .ArbMode(1), .StampTag(1), .TagPortLsb(TL)) dut_fp (
        .clk(clk), .rstn(rstn), .smiReqInReady(in_rdy), .smiReqInEofc(in_eofc), .smiReqInData(in_data),
        .smiReqInStop(stop_fp), .smiReqOutReady(ordy_fp), .smiReqOutEofc(oeofc_fp), .smiReqOutData(odata_fp),
        .smiReqOutStop(out_stop), .grantValid(gv_fp), .grantIdx(gi_fp));

    assign stop_s  = sel ? stop_fp  : stop_rr;
    assign ordy_s  = sel ? ordy_fp  : ordy_rr;
    assign oeofc_s = sel ? oeofc_fp : oeofc_rr;
    assign odata_s = sel ? odata_fp : odata_rr;
    assign gv_s    = sel ? gv_fp    : gv_rr;
    assign gi_s    = sel ? gi_fp    : gi_rr;

    int    checks = 0;
    int    fails  = 0;
    int    cyc    = 0;
    flit_t src_q[NP][$];
    flit_t exp_q[$];
    int    exp_g[$];
    int    out_cyc[$];
    int    pops[NP];
    int    gcnt[NP];
    bit    rand_stop = 1'b0;
    bit    gv_prev = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue one frame on port p and push what the arbiter must emit for it.
    task automatic add_frame(input int p, input int n, input logic [7:0] last_eofc);
        flit_t f, e;
        exp_g.push_back(p);
        for (int i = 0; i < n; i++) begin
            f.data = $urandom;
            f.eofc = (i == n - 1) ? last_eofc : 8'd0;
            e = f;
            if (i == 0) e.data[TL +: 2] = 2'(p);
            src_q[p].push_back(f);
            exp_q.push_back(e);
        end
    endtask

    // Source model + output/grant monitor. Sampling happens on negedge,
    // driving one time unit after posedge.
    always begin
        logic [NP-1:0] xf;
        flit_t         e;
        int            g;
        @(negedge clk);
        cyc++;
        xf = in_rdy & ~stop_s;
        if (ordy_s && !out_stop) begin
            chk("out_has_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_flit", 64'({oeofc_s, odata_s}), 64'(e));
                out_cyc.push_back(cyc);
            end
        end
        if (gv_s && !gv_prev) begin
            gcnt[gi_s]++;
            chk("grant_has_expected", 64'(exp_g.size() > 0), 64'd1);
            if (exp_g.size() > 0) begin
                g = exp_g.pop_front();
                chk("grant_idx", 64'(gi_s), 64'(g));
            end
        end
        gv_prev = gv_s;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (xf[p] && src_q[p].size() > 0) begin
                void'(src_q[p].pop_front());
                pops[p]++;
            end
            if (src_q[p].size() > 0) begin
                in_rdy[p]            = 1'b1;
                in_eofc[8*p +: 8]    = src_q[p][0].eofc;
                in_data[DW*p +: DW]  = src_q[p][0].data;
            end else begin
                in_rdy[p]            = 1'b0;
                in_eofc[8*p +: 8]    = 8'd0;
                in_data[DW*p +: DW]  = '0;
            end
        end
        if (rand_stop) out_stop = 1'($urandom_range(0, 1));
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_oready"}, 64'(ordy_rr), 64'd0);
        chk({tag, "_oeofc"},  64'(oeofc_rr), 64'd0);
        chk({tag, "_odata"},  64'(odata_rr), 64'd0);
        chk({tag, "_istop"},  64'(stop_rr), 64'hF);
        chk({tag, "_gv"},     64'(gv_rr), 64'd0);
        chk({tag, "_gi"},     64'(gi_rr), 64'd0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        for (int p = 0; p < NP; p++) begin
            pops[p] = 0;
            gcnt[p] = 0;
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int left;
        left = 0;
        for (int i = 0; i < budget; i++) begin
            left = exp_q.size() + exp_g.size();
            for (int p = 0; p < NP; p++) left += src_q[p].size();
            if (left == 0) break;
            @(negedge clk);
        end
        chk({tag, "_drained"}, 64'(left), 64'd0);
    endtask

    initial begin
        int s;
        bit seen;

        // 1: four simultaneous 3-flit frames, RR from reset -> 0,1,2,3
        do_reset();
        for (int p = 0; p < NP; p++) add_frame(p, 3, 8'd4);
        wait_drain("rr4", 200);

        // 2: ports 1 and 3 stream 8 frames each -> 1,3,1,3,...
        do_reset();
        for (int i = 0; i < 8; i++) begin
            add_frame(1, 2, 8'd4);
            add_frame(3, 2, 8'd4);
        end
        wait_drain("rr_fair", 400);
        chk("rr_cnt1", 64'(gcnt[1]), 64'd8);
        chk("rr_cnt3", 64'(gcnt[3]), 64'd8);

        // 3: fixed priority, port 0 continuous then port 2 -> 0,0,0,2,2
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) add_frame(0, 2, 8'd4);
        for (int i = 0; i < 2; i++) add_frame(2, 2, 8'd4);
        wait_drain("fp", 200);
        sel = 1'b0;

        // 4: 16-flit frame under random downstream stop
        do_reset();
        rand_stop = 1'b1;
        add_frame(0, 16, 8'd3);
        for (int i = 0; i < 100 && pops[0] < 4; i++) @(negedge clk);
        #2;
        s = int'(stop_rr);
        out_stop = ~out_stop;
        #1;
        chk("stop_no_comb_path", 64'(stop_rr), 64'(s));
        out_stop = ~out_stop;
        wait_drain("stall16", 400);
        rand_stop = 1'b0;
        @(posedge clk);
        #2;
        out_stop = 1'b0;

        // 5: back-to-back single-flit frames: gv toggles, 1 flit / 2 cycles
        do_reset();
        out_cyc.delete();
        for (int i = 0; i < 4; i++) add_frame(0, 1, 8'd4);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gv_rr) begin
                seen = 1'b1;
                break;
            end
        end
        chk("single_gv_seen", 64'(seen), 64'd1);
        for (int i = 0; i < 7; i++) begin
            chk("single_gv_toggle", 64'(gv_rr), 64'((i % 2) == 0));
            @(negedge clk);
        end
        wait_drain("single", 100);
        chk("single_out_count", 64'(out_cyc.size()), 64'd4);
        for (int i = 1; i < out_cyc.size(); i++)
            chk("single_out_gap", 64'(out_cyc[i] - out_cyc[i-1]), 64'd2);

        // 6: reset mid-frame after flit 2 of 5, then port 1 regrant
        do_reset();
        add_frame(0, 5, 8'd4);
        for (int i = 0; i < 50 && pops[0] < 2; i++) @(negedge clk);
        chk("midrst_pops", 64'(pops[0]), 64'd2);
        #2;
        rstn = 1'b0;
        #1;
        chk_reset_vals("midrst");
        for (int p = 0; p < NP; p++) src_q[p].delete();
        exp_q.delete();
        exp_g.delete();
        @(posedge clk);
        #1;
        chk("midrst_hold_istop", 64'(stop_rr), 64'hF);
        chk("midrst_hold_oready", 64'(ordy_rr), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        add_frame(1, 1, 8'd4);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            if (in_rdy[1]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("midrst_req_seen", 64'(seen), 64'd1);
        @(posedge clk);
        #2;
        chk("midrst_regrant_gv", 64'(gv_rr), 64'd1);
        chk("midrst_regrant_gi", 64'(gi_rr), 64'd1);
        wait_drain("midrst", 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
